student_fir_mc_sched: RTL and testbench

Multi-channel sample scheduler in front of a single student_fir core. It accepts per-channel audio samples on independent valid strobes (e.g. L/R from the I2S LRCLK edges, or more channels in TDM mode). Samples are buffered one deep per channel and dispatched to the FIR core in round-robin order. Each FIR result is routed back to its channel's output register, with latency, overrun and timeout monitoring.

---
 rtl/student_fir_mc_sched.sv | 142 ++++++++++++++
 tb/tb_student_fir_mc_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/student_fir_mc_sched.sv
// student_fir_mc_sched: round-robin multi-channel sample scheduler in front of one FIR core
module student_fir_mc_sched #(
  parameter int NumCh          = 2,
  parameter int DataSize       = 16,
  parameter int DataSizeFirOut = 24,
  parameter int CntWidth       = 16,
  parameter int TimeoutCycles  = 4096
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumCh-1:0]                ch_valid_i,
  input  logic [NumCh*DataSize-1:0]       ch_sample_i,
  input  logic                            clear_i,
  output logic                            fir_valid_strobe_o,
  output logic [DataSize-1:0]             fir_sample_o,
  input  logic                            fir_valid_strobe_i,
  input  logic [DataSizeFirOut-1:0]       fir_y_i,
  output logic [NumCh*DataSizeFirOut-1:0] y_o,
  output logic [NumCh-1:0]                y_valid_o,
  output logic                            busy_o,
  output logic [NumCh-1:0]                overrun_o,
  output logic                            timeout_o,
  output logic [CntWidth-1:0]             latency_o,
  output logic [CntWidth-1:0]             max_latency_o
);
  localparam int PW = NumCh > 1 ? $clog2(NumCh) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  state_e                          state_q, state_d;
  logic [NumCh*DataSize-1:0]       hold_q, hold_d;
  logic [NumCh-1:0]                pend_q, pend_d, ovr_q, ovr_d, yv_q, yv_d, issue_mask;
  logic [PW-1:0]                   rr_q, rr_d, sel_q, sel_d, nsel, sel_nxt, idx;
  logic [CntWidth-1:0]             lat_q, lat_d, latency_q, latency_d, max_q, max_d;
  logic [DataSize-1:0]             last_q, last_d;
  logic [NumCh*DataSizeFirOut-1:0] y_q, y_d;
  logic                            to_q, to_d;

  // the channel being issued this cycle may be re-strobed without counting as an overrun
  assign issue_mask = state_q == ISSUE ? NumCh'(1) << sel_q : '0;
  assign pend_d     = (pend_q & ~issue_mask) | ch_valid_i;
  assign sel_nxt    = sel_q == PW'(NumCh - 1) ? '0 : sel_q + 1'b1;

  // sample capture: the newest strobed sample overwrites the channel's hold register
  always_comb begin
    hold_d = hold_q;
    for (int c = 0; c < NumCh; c++)
      if (ch_valid_i[c]) hold_d[c*DataSize +: DataSize] = ch_sample_i[c*DataSize +: DataSize];
  end

  // round-robin pick: first pending channel at or above rr_q, wrapping around
  always_comb begin
    nsel = rr_q;
    idx  = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_q) + i) % NumCh);
      if (pend_q[idx]) nsel = idx;
    end
  end

  // dispatch FSM: issue, wait for the FIR answer or give up, route the result to its channel
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    lat_d     = lat_q;
    last_d    = last_q;
    y_d       = y_q;
    yv_d      = '0;
    latency_d = latency_q;
    max_d     = clear_i ? '0 : max_q;
    to_d      = to_q & ~clear_i;
    ovr_d     = (clear_i ? '0 : ovr_q) | (ch_valid_i & pend_q & ~issue_mask);
    case (state_q)
      IDLE: if (|pend_q) begin
        sel_d   = nsel;
        state_d = ISSUE;
      end
      ISSUE: begin
        last_d  = hold_q[sel_q*DataSize +: DataSize];
        lat_d   = CntWidth'(1);
        state_d = WAIT;
      end
      WAIT: if (fir_valid_strobe_i) begin
        y_d[sel_q*DataSizeFirOut +: DataSizeFirOut] = fir_y_i;
        yv_d[sel_q] = 1'b1;
        latency_d   = lat_q;
        max_d       = (clear_i || lat_q > max_q) ? lat_q : max_q;
        rr_d        = sel_nxt;
        state_d     = IDLE;
      end else if (lat_q == CntWidth'(TimeoutCycles)) begin
        to_d    = 1'b1;
        rr_d    = sel_nxt;
        state_d = IDLE;
      end else begin
        lat_d = &lat_q ? lat_q : lat_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      yv_q      <= '0;
      rr_q      <= '0;
      sel_q     <= '0;
      lat_q     <= '0;
      latency_q <= '0;
      max_q     <= '0;
      last_q    <= '0;
      y_q       <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      yv_q      <= yv_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      lat_q     <= lat_d;
      latency_q <= latency_d;
      max_q     <= max_d;
      last_q    <= last_d;
      y_q       <= y_d;
      to_q      <= to_d;
    end
  end

  assign fir_valid_strobe_o = state_q == ISSUE;
  assign fir_sample_o       = state_q == ISSUE ? hold_q[sel_q*DataSize +: DataSize] : last_q;
  assign y_o                = y_q;
  assign y_valid_o          = yv_q;
  assign busy_o             = state_q != IDLE;
  assign overrun_o          = ovr_q;
  assign timeout_o          = to_q;
  assign latency_o          = latency_q;
  assign max_latency_o      = max_q;
endmodule

// File: tb/tb_student_fir_mc_sched.sv
// tb_student_fir_mc_sched: scoreboard bench with random sample batches and a responding FIR model
module tb_student_fir_mc_sched;
  localparam int N = 4, DS = 16, DW = 24, CW = 16, TO = 16;

  logic            clk = 1'b0, rst_ni = 1'b0;
  logic [N-1:0]    ch_valid_i = '0;
  logic [N*DS-1:0] ch_sample_i = '0;
  logic            clear_i = 1'b0, fir_valid_strobe_i = 1'b0;
  logic [DW-1:0]   fir_y_i = '0;
  logic            fir_valid_strobe_o, busy_o, timeout_o;
  logic [DS-1:0]   fir_sample_o;
  logic [N*DW-1:0] y_o;
  logic [N-1:0]    y_valid_o, overrun_o;
  logic [CW-1:0]   latency_o, max_latency_o;

  student_fir_mc_sched #(.NumCh(N), .DataSize(DS), .DataSizeFirOut(DW), .CntWidth(CW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ch_valid_i(ch_valid_i), .ch_sample_i(ch_sample_i), .clear_i(clear_i),
    .fir_valid_strobe_o(fir_valid_strobe_o), .fir_sample_o(fir_sample_o),
    .fir_valid_strobe_i(fir_valid_strobe_i), .fir_y_i(fir_y_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
    .latency_o(latency_o), .max_latency_o(max_latency_o));

  always #5 clk = ~clk;

  typedef struct { int ch; logic [DS-1:0] smp; } disp_t;
  typedef struct { int ch; logic [DW-1:0] y; int lat; int mx; } res_t;
  disp_t disp_q[$];
  res_t  res_q[$];
  int    delay_q[$];
  int    total = 0, bad = 0;
  int    clr_cnt = 0, rst_cnt = 0, spur_cnt = 0, m_rr = 0;
  bit    no_resp = 0, resp_busy = 0;
  logic [DS-1:0] v1 [N];
  logic [DS-1:0] v2 [N];
  int    r_seen_clr = 0, r_seen_rst = 0, r_spur_done = 0, r_max = 0, r_last_lat = 0, r_d = 0;
  bit    r_to = 0;
  logic [DW-1:0] r_y;
  disp_t r_e;
  res_t  m_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fir_stb"}, fir_valid_strobe_o, 0);
    chk({tag, "_fir_smp"}, fir_sample_o, 0);
    chk({tag, "_y_nz"}, |y_o, 0);
    chk({tag, "_yv"}, y_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ovr"}, overrun_o, 0);
    chk({tag, "_to"}, timeout_o, 0);
    chk({tag, "_lat"}, latency_o, 0);
    chk({tag, "_max"}, max_latency_o, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(disp_q.size() == 0 && res_q.size() == 0 && !busy_o && !resp_busy) && n < 400);
    chk("drain_timeout", n >= 400, 0);
  endtask

  // strobe s1 in one cycle, s2 the next; expected order is an upward sweep from the first s1 channel at/after rr
  task automatic run_batch(input logic [N-1:0] s1, input logic [N-1:0] s2);
    logic [N-1:0] all;
    int first, last, c;
    all   = s1 | s2;
    first = -1;
    for (int i = 0; i < N; i++)
      if (first < 0 && s1[(m_rr + i) % N]) first = (m_rr + i) % N;
    last = first;
    for (int i = 0; i < N; i++) begin
      c = (first + i) % N;
      if (all[c]) begin
        disp_q.push_back(disp_t'{ch: c, smp: s2[c] ? v2[c] : v1[c]});
        last = c;
      end
    end
    m_rr = (last + 1) % N;
    tick();
    for (int k = 0; k < N; k++) ch_sample_i[k*DS +: DS] = v1[k];
    ch_valid_i = s1;
    tick();
    for (int k = 0; k < N; k++) ch_sample_i[k*DS +: DS] = v2[k];
    ch_valid_i = s2;
    tick();
    ch_valid_i = '0;
    chk("overrun", overrun_o, s1 & s2);
    clear_i = 1'b1;
    clr_cnt++;
    tick();
    clear_i = 1'b0;
    chk("overrun_clr", overrun_o, 0);
    wait_idle();
  endtask

  // FIR model: checks each dispatched sample, then answers after a chosen delay (0 = never answers)
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) continue;
      if (rst_cnt != r_seen_rst) begin
        r_seen_rst = rst_cnt;
        r_last_lat = 0;
        r_max      = 0;
        r_to       = 0;
      end
      if (clr_cnt != r_seen_clr) begin
        r_seen_clr = clr_cnt;
        r_max      = 0;
        r_to       = 0;
      end
      if (fir_valid_strobe_o) begin
        resp_busy = 1;
        if (disp_q.size() == 0) begin
          chk("unexpected_dispatch", 1, 0);
          r_e = disp_t'{ch: 0, smp: '0};
        end else begin
          r_e = disp_q.pop_front();
          chk("dispatch_sample", fir_sample_o, r_e.smp);
        end
        if (!no_resp) begin
          r_d = delay_q.size() != 0 ? delay_q.pop_front() : $urandom_range(0, 10);
          if (r_d == 0) begin
            repeat (TO) @(posedge clk);
            #1 chk("timeout_early", timeout_o, r_to);
            @(posedge clk);
            #1 chk("timeout_set", timeout_o, 1);
            r_to = 1;
          end else begin
            r_y = DW'($urandom);
            repeat (r_d) @(posedge clk);
            #1;
            fir_valid_strobe_i = 1'b1;
            fir_y_i = r_y;
            if (r_d > r_max) r_max = r_d;
            r_last_lat = r_d;
            res_q.push_back(res_t'{ch: r_e.ch, y: r_y, lat: r_d, mx: r_max});
            @(posedge clk);
            #1 fir_valid_strobe_i = 1'b0;
          end
        end
        resp_busy = 0;
      end else if (spur_cnt != r_spur_done) begin
        r_spur_done++;
        fir_valid_strobe_i = 1'b1;
        fir_y_i = DW'($urandom);
        @(posedge clk);
        #1 fir_valid_strobe_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_latency", latency_o, r_last_lat);
        chk("spur_busy", busy_o, 0);
      end
    end
  end

  // result monitor: every y_valid pulse must match the next expected result
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && y_valid_o != '0) begin
        if (res_q.size() == 0) chk("unexpected_y_valid", y_valid_o, 0);
        else begin
          m_r = res_q.pop_front();
          chk("y_valid", y_valid_o, N'(1) << m_r.ch);
          chk("y_slice", y_o[m_r.ch*DW +: DW], m_r.y);
          chk("latency", latency_o, m_r.lat);
          chk("max_latency", max_latency_o, m_r.mx);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] s1, s2;
    #12 check_all_zero("reset");
    @(posedge clk);
    #1 rst_ni = 1'b1;
    tick();
    delay_q = '{5, 5};
    v1[0] = 16'h0011;
    v1[1] = 16'h0022;
    run_batch(4'b0011, 4'b0000);
    delay_q = '{2};
    v1[0] = 16'h0001;
    v2[0] = 16'h0002;
    run_batch(4'b0001, 4'b0001);
    delay_q = '{3, 9, 4};
    for (int c = 0; c < N; c++) v1[c] = DS'($urandom);
    run_batch(4'b0111, 4'b0000);
    chk("max_after_var", max_latency_o, 9);
    chk("latency_last", latency_o, 4);
    delay_q = '{0, 2};
    run_batch(4'b1001, 4'b0000);
    chk("timeout_sticky", timeout_o, 1);
    spur_cnt++;
    repeat (6) tick();
    for (int t = 0; t < 30; t++) begin
      s1 = N'($urandom_range(1, 15));
      s2 = $urandom_range(0, 1) ? N'($urandom_range(0, 15)) : '0;
      for (int c = 0; c < N; c++) begin
        v1[c] = DS'($urandom);
        v2[c] = DS'($urandom);
      end
      run_batch(s1, s2);
    end
    no_resp = 1;
    v1[2] = 16'hBEEF;
    disp_q.push_back(disp_t'{ch: 2, smp: 16'hBEEF});
    ch_sample_i[2*DS +: DS] = v1[2];
    ch_valid_i = 4'b0100;
    tick();
    ch_valid_i = '0;
    repeat (4) tick();
    chk("busy_in_wait", busy_o, 1);
    #2 rst_ni = 1'b0;
    rst_cnt++;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 rst_ni = 1'b1;
    m_rr = 0;
    spur_cnt++;
    repeat (6) tick();
    check_all_zero("post_rst");
    chk("disp_drained", disp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
